// File: rtl/tp_timing_gen_pkg.sv
// Shared types and constants for the test-pattern timing generator:
// pattern modes, the timing record, reset defaults and the colour-bar table.
package tp_pkg;

  localparam int TP_CW = 16;

  localparam int DEF_HSYNC_LEN    = 62;
  localparam int DEF_H_POST_AMBLE = 60;
  localparam int DEF_H_SIZE       = 720;
  localparam int DEF_H_PRE_AMBLE  = 16;
  localparam int DEF_VSYNC_LEN    = 6;
  localparam int DEF_V_POST_AMBLE = 30;
  localparam int DEF_V_SIZE       = 480;
  localparam int DEF_V_PRE_AMBLE  = 9;

  typedef enum logic [2:0] {
    MODE_RAMP    = 3'd0,
    MODE_BARS    = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_GREY    = 3'd3,
    MODE_XHATCH  = 3'd4
  } mode_e;

  // Field order matches the CFG_H_i / CFG_V_i bus layout {pre, size, post, sync}.
  typedef struct packed {
    logic [TP_CW-1:0] pre;
    logic [TP_CW-1:0] size;
    logic [TP_CW-1:0] post;
    logic [TP_CW-1:0] sync;
  } timing_t;

  // {R, G, B} on/off for bars white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    logic [2:0] rgb;
    case (idx)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/tp_timing_gen_if.sv
// Configuration, pattern and timing-flag bundle of the pattern generator.
interface tp_timing_gen_if #(
  parameter int C_DW = 8,
  parameter int C_CW = 16,
  parameter int C_FW = 8
);
  logic              CKE_i;
  logic              CFG_WE_i;
  logic [4*C_CW-1:0] CFG_H_i;
  logic [4*C_CW-1:0] CFG_V_i;
  logic [2:0]        MODE_i;
  logic              CFG_PEND_o;
  logic [C_DW-1:0]   QQ_R_o;
  logic [C_DW-1:0]   QQ_G_o;
  logic [C_DW-1:0]   QQ_B_o;
  logic              DEN_o;
  logic              HD_o;
  logic              VD_o;
  logic              XH_BLANK_o;
  logic              XV_BLANK_o;
  logic              FS_o;
  logic [C_CW-1:0]   H_CTR_o;
  logic [C_CW-1:0]   V_CTR_o;
  logic [C_FW-1:0]   F_CTR_o;

  modport slave (
    input  CKE_i, CFG_WE_i, CFG_H_i, CFG_V_i, MODE_i,
    output CFG_PEND_o, QQ_R_o, QQ_G_o, QQ_B_o, DEN_o, HD_o, VD_o,
           XH_BLANK_o, XV_BLANK_o, FS_o, H_CTR_o, V_CTR_o, F_CTR_o
  );

  modport master (
    output CKE_i, CFG_WE_i, CFG_H_i, CFG_V_i, MODE_i,
    input  CFG_PEND_o, QQ_R_o, QQ_G_o, QQ_B_o, DEN_o, HD_o, VD_o,
           XH_BLANK_o, XV_BLANK_o, FS_o, H_CTR_o, V_CTR_o, F_CTR_o
  );
endinterface

// File: rtl/tp_timing_gen_axis_ctr.sv
// One raster axis: counter with wrap, sync-active and window-valid decode.
module tp_axis_ctr
  import tp_pkg::*;
(
  input  logic             CK,
  input  logic             SR,
  input  logic             i_en,
  input  logic             i_inc,
  input  timing_t          i_tim,
  output logic [TP_CW-1:0] o_ctr,
  output logic             o_wrap,
  output logic             o_sync,
  output logic             o_vld,
  output logic [TP_CW-1:0] o_pos
);

  logic [TP_CW-1:0] r_ctr;
  logic [TP_CW+1:0] w_start;
  logic [TP_CW+1:0] w_end;
  logic [TP_CW+1:0] w_tot;
  logic [TP_CW+1:0] w_ctr_x;
  logic             w_last;

  // Two guard bits keep the field sums from overflowing.
  assign w_start = {2'b00, i_tim.sync} + {2'b00, i_tim.post};
  assign w_end   = w_start + {2'b00, i_tim.size};
  assign w_tot   = w_end + {2'b00, i_tim.pre};
  assign w_ctr_x = {2'b00, r_ctr};

  // >= rather than == lets a shrunken total recover in one step.
  assign w_last = (w_ctr_x + (TP_CW+2)'(1)) >= w_tot;
  assign o_wrap = i_en & i_inc & w_last;
  assign o_sync = r_ctr < i_tim.sync;
  assign o_vld  = (w_ctr_x >= w_start) && (w_ctr_x < w_end);
  assign o_pos  = r_ctr - w_start[TP_CW-1:0];
  assign o_ctr  = r_ctr;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CK) begin
    if (SR) begin
      r_ctr <= '0;
    end else if (i_en && i_inc) begin
      r_ctr <= w_last ? '0 : r_ctr + TP_CW'(1);
    end
  end

endmodule

// File: rtl/tp_timing_gen.sv
// Programmable HD/VD/DEN timing generator with selectable RGB test patterns.
// New timing is shadowed and swapped in only at the frame boundary.
module tp_timing_gen
  import tp_pkg::*;
#(
  parameter int C_DW             = 8,
  parameter int C_CW             = TP_CW,  // must equal TP_CW
  parameter int C_FW             = 8,
  parameter int C_HSYNC_LEN      = DEF_HSYNC_LEN,
  parameter int C_H_POST_AMBLE   = DEF_H_POST_AMBLE,
  parameter int C_H_SIZE         = DEF_H_SIZE,
  parameter int C_H_PRE_AMBLE    = DEF_H_PRE_AMBLE,
  parameter int C_VSYNC_LEN      = DEF_VSYNC_LEN,
  parameter int C_V_POST_AMBLE   = DEF_V_POST_AMBLE,
  parameter int C_V_SIZE         = DEF_V_SIZE,
  parameter int C_V_PRE_AMBLE    = DEF_V_PRE_AMBLE,
  parameter bit C_HD_POL         = 1'b1,
  parameter bit C_VD_POL         = 1'b1,
  parameter int C_CHK_LOG2       = 4
) (
  input logic            CK,
  input logic            SR,
  tp_timing_gen_if.slave bus
);

  localparam timing_t H_RST = '{pre: TP_CW'(C_H_PRE_AMBLE), size: TP_CW'(C_H_SIZE),
                                post: TP_CW'(C_H_POST_AMBLE), sync: TP_CW'(C_HSYNC_LEN)};
  localparam timing_t V_RST = '{pre: TP_CW'(C_V_PRE_AMBLE), size: TP_CW'(C_V_SIZE),
                                post: TP_CW'(C_V_POST_AMBLE), sync: TP_CW'(C_VSYNC_LEN)};
  localparam logic [C_DW-1:0] FULL = '1;

  timing_t          r_act_h, r_act_v, r_shd_h, r_shd_v;
  logic             r_pend;
  mode_e            r_mode;
  logic [C_FW-1:0]  r_f;
  logic [TP_CW-1:0] r_bar_sub;
  logic [2:0]       r_bar_idx;
  logic             r_hd, r_vd, r_xh, r_xv, r_den, r_fs;
  logic [C_DW-1:0]  r_r, r_g, r_b;

  logic [TP_CW-1:0] w_h_ctr, w_h_pos, w_v_ctr, w_v_pos, w_bar_w;
  logic             w_h_wrap, w_h_sync, w_h_vld;
  logic             w_frame_wrap, w_v_sync, w_v_vld;
  logic [C_DW-1:0]  w_x, w_y, w_f, w_r, w_g, w_b;
  logic [2:0]       w_bar;

  tp_axis_ctr u_h (
    .CK(CK), .SR(SR), .i_en(bus.CKE_i), .i_inc(1'b1), .i_tim(r_act_h),
    .o_ctr(w_h_ctr), .o_wrap(w_h_wrap), .o_sync(w_h_sync), .o_vld(w_h_vld), .o_pos(w_h_pos)
  );

  // The V axis steps on the H wrap, so its wrap is the frame wrap.
  tp_axis_ctr u_v (
    .CK(CK), .SR(SR), .i_en(bus.CKE_i), .i_inc(w_h_wrap), .i_tim(r_act_v),
    .o_ctr(w_v_ctr), .o_wrap(w_frame_wrap), .o_sync(w_v_sync), .o_vld(w_v_vld), .o_pos(w_v_pos)
  );

  // Shadow capture is CKE-independent; a coincident write re-arms PEND.
  always_ff @(posedge CK) begin
    if (SR) begin
      r_act_h <= H_RST;
      r_act_v <= V_RST;
      r_shd_h <= H_RST;
      r_shd_v <= V_RST;
      r_pend  <= 1'b0;
      r_mode  <= MODE_RAMP;
      r_f     <= '0;
    end else begin
      if (w_frame_wrap) begin
        r_mode <= mode_e'(bus.MODE_i);
        r_f    <= r_f + C_FW'(1);
        if (r_pend) begin
          r_act_h <= r_shd_h;
          r_act_v <= r_shd_v;
        end
      end
      if (bus.CFG_WE_i) begin
        r_shd_h <= timing_t'(bus.CFG_H_i);
        r_shd_v <= timing_t'(bus.CFG_V_i);
      end
      r_pend <= bus.CFG_WE_i | (r_pend & ~w_frame_wrap);
    end
  end

  // Bar state tracks the pixel currently addressed by the H counter.
  assign w_bar_w = r_act_h.size >> 3;

  always_ff @(posedge CK) begin
    if (SR) begin
      r_bar_sub <= '0;
      r_bar_idx <= '0;
    end else if (bus.CKE_i) begin
      if (w_h_wrap || !w_h_vld) begin
        r_bar_sub <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_sub + TP_CW'(1) == w_bar_w) begin
        r_bar_sub <= '0;
        if (r_bar_idx != 3'd7) r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_sub <= r_bar_sub + TP_CW'(1);
      end
    end
  end

  assign w_x   = C_DW'(w_h_pos);
  assign w_y   = C_DW'(w_v_pos);
  assign w_f   = C_DW'(r_f);
  assign w_bar = bar_rgb(r_bar_idx);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_mode)
      MODE_RAMP: begin
        w_r = w_x + w_f;
        w_g = w_y + w_f;
        w_b = w_x + w_y - w_f;
      end
      MODE_BARS: begin
        if (w_bar_w != '0) begin
          w_r = w_bar[2] ? FULL : '0;
          w_g = w_bar[1] ? FULL : '0;
          w_b = w_bar[0] ? FULL : '0;
        end
      end
      MODE_CHECKER: begin
        if (w_h_pos[C_CHK_LOG2] ^ w_v_pos[C_CHK_LOG2]) begin
          w_r = FULL; w_g = FULL; w_b = FULL;
        end
      end
      MODE_GREY: begin
        w_r = {1'b1, {(C_DW-1){1'b0}}};
        w_g = {1'b1, {(C_DW-1){1'b0}}};
        w_b = {1'b1, {(C_DW-1){1'b0}}};
      end
      MODE_XHATCH: begin
        if (w_h_pos[C_CHK_LOG2-1:0] == '0 || w_v_pos[C_CHK_LOG2-1:0] == '0) begin
          w_r = FULL; w_g = FULL; w_b = FULL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      r_hd  <= ~C_HD_POL;
      r_vd  <= ~C_VD_POL;
      r_xh  <= 1'b0;
      r_xv  <= 1'b0;
      r_den <= 1'b0;
      r_fs  <= 1'b0;
      r_r   <= '0;
      r_g   <= '0;
      r_b   <= '0;
    end else if (bus.CKE_i) begin
      r_hd  <= w_h_sync ? C_HD_POL : ~C_HD_POL;
      r_vd  <= w_v_sync ? C_VD_POL : ~C_VD_POL;
      r_xh  <= w_h_vld;
      r_xv  <= w_v_vld;
      r_den <= w_h_vld & w_v_vld;
      r_fs  <= (w_h_ctr == '0) && (w_v_ctr == '0);
      r_r   <= (w_h_vld & w_v_vld) ? w_r : '0;
      r_g   <= (w_h_vld & w_v_vld) ? w_g : '0;
      r_b   <= (w_h_vld & w_v_vld) ? w_b : '0;
    end
  end

  assign bus.CFG_PEND_o = r_pend;
  assign bus.QQ_R_o     = r_r;
  assign bus.QQ_G_o     = r_g;
  assign bus.QQ_B_o     = r_b;
  assign bus.DEN_o      = r_den;
  assign bus.HD_o       = r_hd;
  assign bus.VD_o       = r_vd;
  assign bus.XH_BLANK_o = r_xh;
  assign bus.XV_BLANK_o = r_xv;
  assign bus.FS_o       = r_fs;
  assign bus.H_CTR_o    = C_CW'(w_h_ctr);
  assign bus.V_CTR_o    = C_CW'(w_v_ctr);
  assign bus.F_CTR_o    = r_f;

endmodule

// File: tb/tb_tp_timing_gen.sv
// Directed bench for tp_timing_gen on a small 22x7 raster (H 2/2/16/2, V 1/1/4/1).
module tb_tp_timing_gen;
  import tp_pkg::*;

  localparam int DW = 8;
  localparam int CW = 16;
  localparam int FW = 8;

  logic CK = 1'b0;
  logic SR = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;  // CKE-qualified edges since reset release

  tp_timing_gen_if #(.C_DW(DW), .C_CW(CW), .C_FW(FW)) ifc ();

  tp_timing_gen #(
    .C_DW(DW), .C_CW(CW), .C_FW(FW),
    .C_HSYNC_LEN(2), .C_H_POST_AMBLE(2), .C_H_SIZE(16), .C_H_PRE_AMBLE(2),
    .C_VSYNC_LEN(1), .C_V_POST_AMBLE(1), .C_V_SIZE(4), .C_V_PRE_AMBLE(1),
    .C_HD_POL(1'b1), .C_VD_POL(1'b1), .C_CHK_LOG2(2)
  ) dut (
    .CK(CK), .SR(SR), .bus(ifc)
  );

  always #5 CK = ~CK;

  typedef struct {
    int          k;
    logic [15:0] h;
    logic [15:0] v;
    logic [7:0]  f;
    logic [5:0]  flg;  // {HD, VD, XH_BLANK, XV_BLANK, DEN, FS}
    logic [23:0] rgb;
  } vec_t;

  typedef struct {
    logic [2:0]  mode;
    logic [23:0] rgb_a;  // x=1, y=0 of frame 1
    logic [23:0] rgb_b;  // x=5, y=1 of frame 1
  } mvec_t;

  vec_t  vecs[15];
  mvec_t mvecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
    if (ifc.CKE_i && !SR) k++;
  endtask

  task automatic run_to(input int t);
    for (int g = 0; g < 2000 && k < t; g++) step();
  endtask

  task automatic do_reset();
    SR = 1'b1;
    ifc.CFG_WE_i = 1'b0;
    ifc.CKE_i = 1'b1;
    step();
    step();
    SR = 1'b0;
    k = 0;
  endtask

  function automatic logic [39:0] cnt();
    return {ifc.H_CTR_o, ifc.V_CTR_o, ifc.F_CTR_o};
  endfunction

  function automatic logic [5:0] flg();
    return {ifc.HD_o, ifc.VD_o, ifc.XH_BLANK_o, ifc.XV_BLANK_o, ifc.DEN_o, ifc.FS_o};
  endfunction

  function automatic logic [23:0] rgb();
    return {ifc.QQ_R_o, ifc.QQ_G_o, ifc.QQ_B_o};
  endfunction

  function automatic vec_t mk(int kk, int h, int v, int f, logic [5:0] fl, logic [23:0] c);
    vec_t r;
    r.k = kk; r.h = 16'(h); r.v = 16'(v); r.f = 8'(f); r.flg = fl; r.rgb = c;
    return r;
  endfunction

  task automatic load_cfg(input logic [63:0] h, input logic [63:0] v);
    ifc.CFG_H_i  = h;
    ifc.CFG_V_i  = v;
    ifc.CFG_WE_i = 1'b1;
    step();
    ifc.CFG_WE_i = 1'b0;
  endtask

  initial begin
    int n, hd_n, den_n;
    logic [63:0] v_def;

    // Output at sample k reflects counter position k-1; counters show position k.
    vecs[0]  = mk(1,   1,  0, 0, 6'b110001, 24'h000000);
    vecs[1]  = mk(2,   2,  0, 0, 6'b110000, 24'h000000);
    vecs[2]  = mk(3,   3,  0, 0, 6'b010000, 24'h000000);
    vecs[3]  = mk(6,   6,  0, 0, 6'b011000, 24'h000000);
    vecs[4]  = mk(23,  1,  1, 0, 6'b100000, 24'h000000);
    vecs[5]  = mk(48,  4,  2, 0, 6'b000100, 24'h000000);
    vecs[6]  = mk(49,  5,  2, 0, 6'b001110, 24'h000000);
    vecs[7]  = mk(64,  20, 2, 0, 6'b001110, 24'h0F000F);
    vecs[8]  = mk(65,  21, 2, 0, 6'b000100, 24'h000000);
    vecs[9]  = mk(98,  10, 4, 0, 6'b001110, 24'h050207);
    vecs[10] = mk(143, 11, 6, 0, 6'b001000, 24'h000000);
    vecs[11] = mk(154, 0,  0, 1, 6'b000000, 24'h000000);
    vecs[12] = mk(155, 1,  0, 1, 6'b110001, 24'h000000);
    vecs[13] = mk(203, 5,  2, 1, 6'b001110, 24'h0101FF);
    vecs[14] = mk(228, 8,  3, 1, 6'b001110, 24'h040203);

    mvecs[0] = '{mode: 3'd2, rgb_a: 24'h000000, rgb_b: 24'hFFFFFF};
    mvecs[1] = '{mode: 3'd3, rgb_a: 24'h808080, rgb_b: 24'h808080};
    mvecs[2] = '{mode: 3'd4, rgb_a: 24'hFFFFFF, rgb_b: 24'h000000};
    mvecs[3] = '{mode: 3'd5, rgb_a: 24'h000000, rgb_b: 24'h000000};

    v_def = {16'd1, 16'd4, 16'd1, 16'd1};
    ifc.CKE_i = 1'b1;
    ifc.CFG_WE_i = 1'b0;
    ifc.CFG_H_i = '0;
    ifc.CFG_V_i = '0;
    ifc.MODE_i = 3'd0;

    do_reset();
    check("reset_cnt", 64'(cnt()), 64'h0);
    check("reset_flags", 64'(flg()), 64'h0);
    check("reset_rgb", 64'(rgb()), 64'h0);
    check("reset_pend", 64'(ifc.CFG_PEND_o), 64'h0);

    // Free-running mode 0 raster.
    for (int i = 0; i < 15; i++) begin
      run_to(vecs[i].k);
      check($sformatf("vec%0d_cnt", i), 64'(cnt()), 64'({vecs[i].h, vecs[i].v, vecs[i].f}));
      check($sformatf("vec%0d_flags", i), 64'(flg()), 64'(vecs[i].flg));
      check($sformatf("vec%0d_rgb", i), 64'(rgb()), 64'(vecs[i].rgb));
    end

    // Frame period and per-frame HD / DEN counts.
    do_reset();
    step();
    n = 0; hd_n = 0; den_n = 0;
    for (int g = 0; g < 400; g++) begin
      step();
      n++;
      hd_n += int'(ifc.HD_o);
      den_n += int'(ifc.DEN_o);
      if (ifc.FS_o) break;
    end
    check("fs_period", 64'(n), 64'd154);
    check("hd_per_frame", 64'(hd_n), 64'd14);
    check("den_per_frame", 64'(den_n), 64'd64);

    // Colour bars requested mid-frame 0; frame 0 stays a ramp.
    do_reset();
    ifc.MODE_i = 3'd0;
    run_to(30);
    ifc.MODE_i = 3'd1;
    run_to(49);  check("bars_f0_x0", 64'(rgb()), 64'h000000);
    run_to(50);  check("bars_f0_x1", 64'(rgb()), 64'h010001);
    run_to(203); check("bars_x0", 64'(rgb()), 64'hFFFFFF);
    run_to(205); check("bars_x2", 64'(rgb()), 64'hFFFF00);
    run_to(216); check("bars_x13", 64'(rgb()), 64'h0000FF);
    run_to(217); check("bars_x14", 64'(rgb()), 64'h000000);
    run_to(218); check("bars_x15", 64'(rgb()), 64'h000000);

    // Remaining patterns, selected before the first frame wrap.
    for (int i = 0; i < 4; i++) begin
      ifc.MODE_i = mvecs[i].mode;
      do_reset();
      run_to(204);
      check($sformatf("mode%0d_a", mvecs[i].mode), 64'(rgb()), 64'(mvecs[i].rgb_a));
      run_to(230);
      check($sformatf("mode%0d_b", mvecs[i].mode), 64'(rgb()), 64'(mvecs[i].rgb_b));
    end
    ifc.MODE_i = 3'd0;

    // Mid-frame config: H size 8 (total 14) applies from frame 1.
    do_reset();
    run_to(9);
    load_cfg({16'd2, 16'd8, 16'd2, 16'd2}, v_def);
    check("mid_pend_set", 64'(ifc.CFG_PEND_o), 64'd1);
    run_to(153);
    check("mid_old_last", 64'(cnt()), 64'({16'd21, 16'd6, 8'd0}));
    check("mid_pend_hold", 64'(ifc.CFG_PEND_o), 64'd1);
    run_to(154);
    check("mid_wrap", 64'(cnt()), 64'({16'd0, 16'd0, 8'd1}));
    check("mid_pend_clr", 64'(ifc.CFG_PEND_o), 64'd0);
    run_to(167); check("mid_new_h13", 64'(cnt()), 64'({16'd13, 16'd0, 8'd1}));
    run_to(168); check("mid_new_wrap", 64'(cnt()), 64'({16'd0, 16'd1, 8'd1}));
    run_to(252); check("mid_new_frame", 64'(cnt()), 64'({16'd0, 16'd0, 8'd2}));

    // Config A pending, config B written on the exact wrap cycle.
    do_reset();
    run_to(20);
    load_cfg({16'd2, 16'd8, 16'd2, 16'd2}, v_def);
    run_to(153);
    load_cfg({16'd2, 16'd4, 16'd2, 16'd2}, v_def);
    check("wrap_we_cnt", 64'(cnt()), 64'({16'd0, 16'd0, 8'd1}));
    check("wrap_we_pend", 64'(ifc.CFG_PEND_o), 64'd1);
    run_to(168); check("wrap_a_line", 64'(cnt()), 64'({16'd0, 16'd1, 8'd1}));
    run_to(251);
    check("wrap_a_last", 64'(cnt()), 64'({16'd13, 16'd6, 8'd1}));
    check("wrap_b_pend", 64'(ifc.CFG_PEND_o), 64'd1);
    run_to(252);
    check("wrap_b_apply", 64'(cnt()), 64'({16'd0, 16'd0, 8'd2}));
    check("wrap_b_pend_clr", 64'(ifc.CFG_PEND_o), 64'd0);
    run_to(261); check("wrap_b_h9", 64'(cnt()), 64'({16'd9, 16'd0, 8'd2}));
    run_to(262); check("wrap_b_line", 64'(cnt()), 64'({16'd0, 16'd1, 8'd2}));

    // Reset mid-line overrides CKE and CFG_WE; restart uses default timing.
    run_to(265);
    ifc.CFG_H_i = {16'd2, 16'd4, 16'd2, 16'd2};
    ifc.CFG_WE_i = 1'b1;
    SR = 1'b1;
    step();
    check("sr_cnt", 64'(cnt()), 64'h0);
    check("sr_flags", 64'(flg()), 64'h0);
    check("sr_rgb", 64'(rgb()), 64'h0);
    check("sr_pend", 64'(ifc.CFG_PEND_o), 64'd0);
    SR = 1'b0;
    ifc.CFG_WE_i = 1'b0;
    k = 0;
    run_to(21); check("sr_restart_h21", 64'(cnt()), 64'({16'd21, 16'd0, 8'd0}));
    run_to(22); check("sr_restart_wrap", 64'(cnt()), 64'({16'd0, 16'd1, 8'd0}));

    // CKE toggling: counters advance on enabled edges, outputs hold otherwise.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ifc.CKE_i = (i % 2 == 0);
      step();
      check($sformatf("cke_h_%0d", i), 64'(ifc.H_CTR_o), 64'(i / 2 + 1));
      check($sformatf("cke_fs_%0d", i), 64'(ifc.FS_o), 64'(i < 2));
    end
    ifc.CKE_i = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
